tron_plot_engine: RTL and testbench
===================================

# tron_plot_engine

Command-driven pixel plotter for the 160x120, 3-bit-colour VGA framebuffer. It drives the `x`/`y`/`colour`/`plot` write port of the VGA adapter, clearing the screen after reset or on command and drawing single trail pixels. It keeps a 1-bit occupancy shadow of the screen, so every point draw also returns a collision verdict to the game FSM.

## Interface
Parameters:
- `SCREEN_W`, default 160: pixel columns.
- `SCREEN_H`, default 120: pixel rows.
- `CLEAR_COLOUR`, default 3'b000: colour written during clear.

Ports (one clock; reset is synchronous and active-low):
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `resetn`  in  1  synchronous reset, active low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  engine accepts a command this cycle.
- `cmd_op`  in  1  0 = POINT, 1 = CLEAR.
- `cmd_x`  in  8  POINT column.
- `cmd_y`  in  7  POINT row.
- `cmd_colour`  in  3  POINT colour (r,g,b).
- `x`  out  8  to the VGA adapter.
- `y`  out  7  to the VGA adapter.
- `colour`  out  3  to the VGA adapter.
- `plot`  out  1  VGA write strobe.
- `result_valid`  out  1  one-cycle pulse at the end of each POINT.
- `result_hit`  out  1  collision flag, qualified by `result_valid`.

## Operation
- States: CLEAR, IDLE, READ, WRITE.
- Reset (`resetn`=0 at a clock edge) forces CLEAR with the scan counters at (0,0), from any state. It also clears `plot`, `x`, `y`, `colour`, `cmd_ready`, `result_valid` and `result_hit` to 0.
- CLEAR:
  - Scans x fastest (0..159), then y (0..119).
  - Each cycle: `plot`=1, `colour`=CLEAR_COLOUR, and the occupancy bit at the scan address is written 0.
  - After (159,119) the engine goes to IDLE.
  - Commands are not accepted during CLEAR.
- IDLE:
  - `cmd_ready`=1 only in IDLE.
  - A handshake occurs when `cmd_valid`&&`cmd_ready`.
  - CLEAR op → CLEAR at (0,0).
  - POINT op → latch x, y and colour, then go to READ.
- READ: occupancy read address = y*160+x, computed as (y<<7)+(y<<5)+x, 15 bits wide. `plot`=0.
- WRITE:
  - `hit` = out_of_range || occupied, where out_of_range = (x≥160)||(y≥120).
  - `result_valid`=1 and `result_hit`=hit.
  - If !hit: `plot`=1 with the latched x, y and colour, and the occupancy bit is set to 1.
  - If hit: `plot`=0 and occupancy is unchanged. An out-of-range address never touches the RAM.
  - Next state is IDLE.
- `cmd_*` fields are ignored when no handshake occurs. Latched values are stable through READ and WRITE.

## Timing
- CLEAR takes exactly 19200 cycles with `plot` high on each. `cmd_ready` rises the cycle after the last clear write.
- POINT timing, with handshake at cycle N:
  - READ at N+1.
  - WRITE at N+2, when `plot` and `result_valid` pulse.
  - IDLE with `cmd_ready`=1 at N+3.
  - Maximum rate is one POINT per 3 cycles.
- The occupancy RAM has synchronous read with 1-cycle latency. Its write port is used in CLEAR and WRITE only.
- A write and a read never target the RAM in the same cycle, so no read-during-write hazard exists.
- A POINT at the same pixel twice in a row: the second command reads the bit written by the first, and reports hit=1.
- Reset mid-POINT: no `result_valid` is produced, and the occupancy state is irrelevant because CLEAR follows.
- `x`, `y` and `colour` are registered outputs. `plot` is never high in IDLE or READ.

## Structure
- Shared package `tron_pkg`: SCREEN_W/H, coordinate widths (8, 7), colour width 3, opcode constants OP_POINT/OP_CLEAR, state encoding, colour constants (BLACK, RED, BLUE, ...).
- Sub-module `occupancy_ram`:
  - 19200x1 with synchronous read.
  - One read port and one write port.
  - Infers M9K; no initial contents are required.
- FSM, scan counters and address arithmetic sit in `tron_plot_engine`.

## Test plan
- Reset, then idle:
  - `plot` stays high for exactly 19200 cycles, covering (0,0)…(159,119) in x-fastest order with colour 0.
  - `cmd_ready` first rises on cycle 19201 after release.
- POINT (10,20,3'b100) on a clean screen → 2 cycles after handshake: `plot`=1, x=10, y=20, colour=4, `result_valid`=1, `result_hit`=0.
- Repeat POINT (10,20,3'b001) → `result_hit`=1, no `plot` pulse.
- POINT (160,5) and POINT (0,120) → `result_hit`=1, no `plot`. A following POINT (0,0) reports hit=0.
- Draw (159,119), then issue CLEAR → 19200-cycle sweep. Re-POINT (159,119) reports hit=0.
- Assert `resetn`=0 one cycle after a POINT handshake:
  - No `result_valid` is produced.
  - A CLEAR sweep restarts at (0,0).
  - Back-to-back `cmd_valid` during CLEAR is never accepted.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared constants, opcodes, palette and FSM encoding for the tron plot engine.
package tron_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;

  localparam logic OP_POINT = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  // Colours are {r,g,b}.
  localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
  localparam logic [COLOUR_W-1:0] BLUE    = 3'b001;
  localparam logic [COLOUR_W-1:0] GREEN   = 3'b010;
  localparam logic [COLOUR_W-1:0] CYAN    = 3'b011;
  localparam logic [COLOUR_W-1:0] RED     = 3'b100;
  localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;
  localparam logic [COLOUR_W-1:0] YELLOW  = 3'b110;
  localparam logic [COLOUR_W-1:0] WHITE   = 3'b111;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/occupancy_ram.sv
// 1-bit-per-pixel occupancy shadow: one synchronous read port, one write port.
module occupancy_ram
  import tron_pkg::*;
#(
  parameter int DEPTH = SCREEN_W * SCREEN_H
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data
);

  // No reset and no initial contents so the array maps onto block RAM.
  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tron_plot_engine.sv
// Command-driven plotter for the 160x120 VGA framebuffer: clears the screen and
// draws trail pixels, reporting a collision verdict for every POINT command.
module tron_plot_engine #(
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic [2:0] cmd_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       result_valid,
  output logic       result_hit
);

  import tron_pkg::*;

  // Handshake: a command is taken on any rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and cmd_* are ignored on every other cycle.

  state_t state, state_next;

  logic [X_W-1:0]      x_r;
  logic [Y_W-1:0]      y_r;
  logic [COLOUR_W-1:0] colour_r;

  logic [ADDR_W-1:0] addr;
  logic              out_of_range;
  logic              occupied;
  logic              hit;
  logic              scan_last_x;
  logic              scan_last;
  logic              ram_rd_en;
  logic              ram_wr_en;
  logic              ram_wr_data;

  // x_r/y_r double as the clear scan counters and the latched POINT address.
  assign addr         = ({8'd0, y_r} << 7) + ({8'd0, y_r} << 5) + {7'd0, x_r};
  assign out_of_range = (x_r >= X_W'(SCREEN_W)) || (y_r >= Y_W'(SCREEN_H));
  assign scan_last_x  = (x_r == X_W'(SCREEN_W - 1));
  assign scan_last    = scan_last_x && (y_r == Y_W'(SCREEN_H - 1));
  assign hit          = out_of_range || occupied;

  always_comb begin
    state_next   = state;
    cmd_ready    = 1'b0;
    plot         = 1'b0;
    result_valid = 1'b0;
    result_hit   = 1'b0;
    ram_rd_en    = 1'b0;
    ram_wr_en    = 1'b0;
    ram_wr_data  = 1'b0;
    case (state)
      ST_CLEAR: begin
        plot      = 1'b1;
        ram_wr_en = 1'b1;
        if (scan_last) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = (cmd_op == OP_CLEAR) ? ST_CLEAR : ST_READ;
      end
      ST_READ: begin
        // Out-of-range addresses would fall outside the array.
        ram_rd_en  = !out_of_range;
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        result_valid = 1'b1;
        result_hit   = hit;
        if (!hit) begin
          plot        = 1'b1;
          ram_wr_en   = 1'b1;
          ram_wr_data = 1'b1;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_CLEAR;
    endcase
    // Reset holds every strobe low while it is asserted.
    if (!resetn) begin
      state_next   = ST_CLEAR;
      cmd_ready    = 1'b0;
      plot         = 1'b0;
      result_valid = 1'b0;
      result_hit   = 1'b0;
      ram_rd_en    = 1'b0;
      ram_wr_en    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state    <= ST_CLEAR;
      x_r      <= '0;
      y_r      <= '0;
      colour_r <= CLEAR_COLOUR;
    end else begin
      state <= state_next;
      case (state)
        ST_CLEAR: begin
          colour_r <= CLEAR_COLOUR;
          if (scan_last) begin
            x_r <= '0;
            y_r <= '0;
          end else if (scan_last_x) begin
            x_r <= '0;
            y_r <= y_r + 7'd1;
          end else begin
            x_r <= x_r + 8'd1;
          end
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == OP_CLEAR) begin
              x_r      <= '0;
              y_r      <= '0;
              colour_r <= CLEAR_COLOUR;
            end else begin
              x_r      <= cmd_x;
              y_r      <= cmd_y;
              colour_r <= cmd_colour;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign x      = x_r;
  assign y      = y_r;
  assign colour = resetn ? colour_r : '0;

  occupancy_ram #(
    .DEPTH(SCREEN_W * SCREEN_H)
  ) u_occupancy_ram (
    .clk    (CLOCK_50),
    .rd_en  (ram_rd_en),
    .rd_addr(addr),
    .rd_data(occupied),
    .wr_en  (ram_wr_en),
    .wr_addr(addr),
    .wr_data(ram_wr_data)
  );

endmodule

// File: tb/tb_tron_plot_engine.sv
// Directed and randomized bench for tron_plot_engine, checked against a
// per-pixel occupancy model of the 160x120 screen.
module tb_tron_plot_engine;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic [2:0] cmd_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       result_valid;
  logic       result_hit;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which on-screen pixels currently carry a trail.
  bit occ [0:159][0:119];

  always #5 CLOCK_50 = ~CLOCK_50;

  tron_plot_engine dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_colour  (cmd_colour),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .result_valid(result_valid),
    .result_hit  (result_hit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++)
        occ[i][j] = 1'b0;
  endtask

  task automatic scramble_cmd_fields();
    cmd_op     = 1'($urandom);
    cmd_x      = 8'($urandom);
    cmd_y      = 7'($urandom);
    cmd_colour = 3'($urandom);
  endtask

  // Entered at the first sweep cycle (just after an edge); returns inside IDLE.
  task automatic clear_sweep(input string tag, input bit hammer);
    int bad = 0;
    int first_bad = -1;
    for (int i = 0; i < 19200; i++) begin
      @(negedge CLOCK_50);
      if (plot !== 1'b1 || x !== 8'(i % 160) || y !== 7'(i / 160) ||
          colour !== 3'b000 || cmd_ready !== 1'b0 || result_valid !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      @(posedge CLOCK_50); #1;
      scramble_cmd_fields();
      if (i == 19199)  cmd_valid = 1'b0;
      else if (hammer) cmd_valid = 1'b1;
      else             cmd_valid = 1'($urandom_range(0, 1));
    end
    if (first_bad >= 0)
      $display("%s: first deviation at sweep cycle %0d (x=%0d y=%0d plot=%0b)",
               tag, first_bad, x, y, plot);
    check({tag, "_pixels"}, bad, 0);
    @(negedge CLOCK_50);
    check({tag, "_ready_after"}, cmd_ready, 1);
    check({tag, "_plot_after"}, plot, 0);
    clear_model();
    @(posedge CLOCK_50); #1;
  endtask

  // Entered in IDLE just after an edge; returns at the next handshake opportunity.
  task automatic do_point(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    bit exp_hit;
    if (px >= 8'd160 || py >= 7'd120) exp_hit = 1'b1;
    else                              exp_hit = occ[px][py];
    cmd_valid  = 1'b1;
    cmd_op     = 1'b0;
    cmd_x      = px;
    cmd_y      = py;
    cmd_colour = pc;
    @(negedge CLOCK_50);
    check("pt_ready", cmd_ready, 1);
    @(posedge CLOCK_50); #1;
    scramble_cmd_fields();
    cmd_valid = 1'($urandom_range(0, 1));
    @(negedge CLOCK_50);
    check("pt_read_plot", plot, 0);
    check("pt_read_valid", result_valid, 0);
    check("pt_read_ready", cmd_ready, 0);
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0;
    @(negedge CLOCK_50);
    check("pt_valid", result_valid, 1);
    check("pt_hit", result_hit, exp_hit);
    check("pt_plot", plot, !exp_hit);
    if (!exp_hit) begin
      check("pt_x", x, px);
      check("pt_y", y, py);
      check("pt_colour", colour, pc);
      occ[px][py] = 1'b1;
    end
    @(posedge CLOCK_50); #1;
  endtask

  initial begin
    logic [7:0] rx;
    logic [6:0] ry;

    // Reset
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    scramble_cmd_fields();
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_plot", plot, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_valid", result_valid, 0);
    check("rst_hit", result_hit, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    clear_sweep("reset_clear", 1'b0);

    // Directed points
    do_point(8'd10, 7'd20, 3'b100);
    do_point(8'd10, 7'd20, 3'b001);
    do_point(8'd160, 7'd5, 3'b010);
    do_point(8'd0, 7'd120, 3'b010);
    do_point(8'd0, 7'd0, 3'b111);
    do_point(8'd255, 7'd127, 3'b011);

    // Randomized points, clustered to provoke collisions
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        rx = 8'($urandom_range(150, 255));
        ry = 7'($urandom_range(110, 127));
      end else begin
        rx = 8'($urandom_range(0, 11));
        ry = 7'($urandom_range(0, 11));
      end
      do_point(rx, ry, 3'($urandom));
    end

    // Corner pixel, then CLEAR command
    do_point(8'd159, 7'd119, 3'b110);
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    @(negedge CLOCK_50);
    check("clr_ready", cmd_ready, 1);
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0;
    clear_sweep("cmd_clear", 1'b0);
    do_point(8'd159, 7'd119, 3'b110);
    do_point(8'd159, 7'd119, 3'b101);

    // Reset one cycle after a POINT handshake
    do_point(8'd5, 7'd5, 3'b010);
    cmd_valid  = 1'b1;
    cmd_op     = 1'b0;
    cmd_x      = 8'd6;
    cmd_y      = 7'd6;
    cmd_colour = 3'b001;
    @(negedge CLOCK_50);
    check("mid_ready", cmd_ready, 1);
    @(posedge CLOCK_50); #1;
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    @(negedge CLOCK_50);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_plot", plot, 0);
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    clear_sweep("mid_reset", 1'b1);
    do_point(8'd5, 7'd5, 3'b011);
    do_point(8'd6, 7'd6, 3'b100);
    do_point(8'd6, 7'd6, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
